// File: rtl/soc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | soc_pkg: shared PMU state, reset-cause and domain-count definitions  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package soc_pkg;

   localparam int NUM_DOMAINS = 12;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PWR_UP  = 3'd1,
      ST_ASSERT  = 3'd2,
      ST_RELEASE = 3'd3,
      ST_DONE    = 3'd4,
      ST_FAULT   = 3'd5
   } pmu_state_e;

   typedef enum logic [1:0] {
      CAUSE_POR   = 2'b00,
      CAUSE_SW    = 2'b01,
      CAUSE_WDT   = 2'b10,
      CAUSE_RETRY = 2'b11
   } rst_cause_e;

endpackage
`default_nettype wire

// File: rtl/edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_det: single-cycle rising-edge pulse from a level input          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/pmu_reset_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pmu_reset_seq: power-up, global reset pulse and release sequencer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pmu_reset_seq
   import soc_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned PWR_SETTLE  = 8,
   parameter int unsigned REL_TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sw_rst_req,
   input  logic                   wdt_timeout,
   input  logic                   init_done,
   input  logic [NUM_DOMAINS-1:0] reset_status,
   output logic [NUM_DOMAINS-1:0] pwr_domain_on,
   output logic                   global_reset,
   output logic [1:0]             rst_cause,
   output logic                   busy,
   output logic                   seq_done,
   output logic                   err_timeout,
   output logic                   fault
);

   localparam logic [15:0] HOLD_LD   = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] SETTLE_LD = 16'(PWR_SETTLE - 1);
   localparam logic [15:0] REL_LD    = 16'(REL_TIMEOUT - 1);

   pmu_state_e             state_q;
   rst_cause_e             cause_q;
   logic [NUM_DOMAINS-1:0] pwr_q;
   logic [15:0]            cnt_q;
   logic                   glob_q, busy_q, done_q, err_q, fault_q;
   logic                   booted_q, retry_q, pend_sw_q, pend_wdt_q;
   logic                   wdt_rise, wdt_req, sw_req, rel_ok, cnt_zero;

   edge_det u_wdt_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (wdt_timeout),
      .rise_o (wdt_rise)
   );

   assign wdt_req  = pend_wdt_q | wdt_rise;
   assign sw_req   = pend_sw_q | sw_rst_req;
   assign rel_ok   = init_done && (reset_status == '0);
   assign cnt_zero = (cnt_q == 16'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cause_q    <= CAUSE_POR;
         pwr_q      <= '0;
         cnt_q      <= 16'd0;
         glob_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         fault_q    <= 1'b0;
         booted_q   <= 1'b0;
         retry_q    <= 1'b0;
         pend_sw_q  <= 1'b0;
         pend_wdt_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         pend_wdt_q <= wdt_req;
         pend_sw_q  <= sw_req;
         // Counter saturates at zero; every state entry below reloads it.
         if (!cnt_zero) cnt_q <= cnt_q - 16'd1;

         case (state_q)
            ST_IDLE: begin
               if (!booted_q) begin
                  booted_q <= 1'b1;
                  state_q  <= ST_PWR_UP;
                  busy_q   <= 1'b1;
                  pwr_q    <= {{(NUM_DOMAINS-1){1'b0}}, 1'b1};
                  cnt_q    <= SETTLE_LD;
                  cause_q  <= CAUSE_POR;
               end else if (wdt_req) begin
                  state_q    <= ST_ASSERT;
                  busy_q     <= 1'b1;
                  glob_q     <= 1'b0;
                  cnt_q      <= HOLD_LD;
                  cause_q    <= CAUSE_WDT;
                  pend_wdt_q <= 1'b0;
               end else if (sw_req) begin
                  state_q   <= ST_ASSERT;
                  busy_q    <= 1'b1;
                  glob_q    <= 1'b0;
                  cnt_q     <= HOLD_LD;
                  cause_q   <= CAUSE_SW;
                  pend_sw_q <= 1'b0;
               end
            end
            ST_PWR_UP: begin
               if (cnt_zero) begin
                  if (pwr_q[NUM_DOMAINS-1]) begin
                     state_q <= ST_ASSERT;
                     glob_q  <= 1'b0;
                     cnt_q   <= HOLD_LD;
                  end else begin
                     pwr_q <= {pwr_q[NUM_DOMAINS-2:0], 1'b1};
                     cnt_q <= SETTLE_LD;
                  end
               end
            end
            ST_ASSERT: begin
               if (cnt_zero) begin
                  state_q <= ST_RELEASE;
                  glob_q  <= 1'b1;
                  cnt_q   <= REL_LD;
               end
            end
            ST_RELEASE: begin
               if (rel_ok) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  cnt_q   <= 16'd0;
               end else if (cnt_zero) begin
                  if (retry_q) begin
                     state_q <= ST_FAULT;
                     glob_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     fault_q <= 1'b1;
                     cnt_q   <= 16'd0;
                  end else begin
                     state_q <= ST_ASSERT;
                     retry_q <= 1'b1;
                     err_q   <= 1'b1;
                     cause_q <= CAUSE_RETRY;
                     glob_q  <= 1'b0;
                     cnt_q   <= HOLD_LD;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               retry_q <= 1'b0;
            end
            ST_FAULT: begin
               // Requests are dropped here, not queued for after the fault.
               pend_wdt_q <= pend_wdt_q;
               pend_sw_q  <= pend_sw_q;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pwr_domain_on = pwr_q;
   assign global_reset  = glob_q;
   assign rst_cause     = cause_q;
   assign busy          = busy_q;
   assign seq_done      = done_q;
   assign err_timeout   = err_q;
   assign fault         = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_pmu_reset_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pmu_reset_seq: scoreboard bench for the PMU reset sequencer       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pmu_reset_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sw_rst_req = 1'b0;
   logic        wdt_timeout = 1'b0;
   logic        init_done = 1'b1;
   logic [11:0] reset_status = 12'h000;
   logic [11:0] pwr_domain_on;
   logic        global_reset;
   logic [1:0]  rst_cause;
   logic        busy, seq_done, err_timeout, fault;

   pmu_reset_seq #(
      .HOLD_CYCLES (16),
      .PWR_SETTLE  (8),
      .REL_TIMEOUT (1024)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sw_rst_req    (sw_rst_req),
      .wdt_timeout   (wdt_timeout),
      .init_done     (init_done),
      .reset_status  (reset_status),
      .pwr_domain_on (pwr_domain_on),
      .global_reset  (global_reset),
      .rst_cause     (rst_cause),
      .busy          (busy),
      .seq_done      (seq_done),
      .err_timeout   (err_timeout),
      .fault         (fault)
   );

   always #21 clk = ~clk;

   typedef struct {
      bit          is_fault;
      logic [1:0]  cause;
      bit          err;
      logic [11:0] pwr;
      int          lowrun;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   lowrun = 0;
   int   last_low = 0;
   logic fault_prev = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic wait_quiet(input int budget, input string nm);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, 32'(n < budget), 1);
   endtask

   task automatic wait_done(input int budget, input string nm);
      int n = 0;
      while (seq_done !== 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, 32'(n < budget), 1);
   endtask

   task automatic wait_fault(input int budget, input string nm);
      int n = 0;
      while (fault !== 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, 32'(n < budget), 1);
   endtask

   task automatic pulse_sw();
      sw_rst_req = 1'b1;
      @(posedge clk); #1;
      sw_rst_req = 1'b0;
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_pwr"},   pwr_domain_on, 0);
      chk({nm, "_grst"},  global_reset, 0);
      chk({nm, "_cause"}, rst_cause, 0);
      chk({nm, "_busy"},  busy, 0);
      chk({nm, "_done"},  seq_done, 0);
      chk({nm, "_err"},   err_timeout, 0);
      chk({nm, "_fault"}, fault, 0);
   endtask

   // Monitor: tracks the length of the last completed global_reset low run
   // and checks each seq_done / fault-entry event against the scoreboard.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst) lowrun = 0;
      else if (global_reset === 1'b0) lowrun++;
      else begin
         if (lowrun != 0) last_low = lowrun;
         lowrun = 0;
      end

      if (seq_done === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_seq_done: got seq_done with no expected event, cause=%0d", rst_cause);
         end else begin
            n_pass++;
            e = sb.pop_front();
            chk("done_fault_flag", fault, e.is_fault);
            chk("done_cause", rst_cause, e.cause);
            chk("done_err", err_timeout, e.err);
            chk("done_pwr", pwr_domain_on, e.pwr);
            chk("done_low_width", last_low, e.lowrun);
         end
      end

      if (fault === 1'b1 && fault_prev !== 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_fault: got fault with no expected event, cause=%0d", rst_cause);
         end else begin
            n_pass++;
            e = sb.pop_front();
            chk("fault_flag", fault, e.is_fault);
            chk("fault_cause", rst_cause, e.cause);
            chk("fault_err", err_timeout, e.err);
            chk("fault_grst", global_reset, 0);
            chk("fault_busy", busy, 0);
         end
      end
      fault_prev = fault;
   end

   initial begin
      repeat (4) @(posedge clk); #1;
      chk_reset_vals("por");

      // Power-on boot: 1 IDLE + 96 PWR_UP + 16 ASSERT cycles of low reset.
      sb.push_back('{1'b0, 2'b00, 1'b0, 12'hFFF, 113});
      rst = 1'b0;
      @(posedge clk); #1;
      chk("boot_bit0", pwr_domain_on, 12'h001);
      chk("boot_busy", busy, 1);
      for (int k = 1; k < 12; k++) begin
         repeat (7) @(posedge clk); #1;
         chk("boot_before_bit", pwr_domain_on, (32'd1 << k) - 1);
         @(posedge clk); #1;
         chk("boot_bit_set", pwr_domain_on, (32'd1 << (k + 1)) - 1);
      end
      repeat (23) @(posedge clk); #1;
      chk("boot_last_low", global_reset, 0);
      @(posedge clk); #1;
      chk("boot_release_high", global_reset, 1);
      wait_quiet(50, "boot_complete");

      // Software reset from IDLE.
      sb.push_back('{1'b0, 2'b01, 1'b0, 12'hFFF, 16});
      pulse_sw();
      chk("sw_grst_low", global_reset, 0);
      chk("sw_cause", rst_cause, 2'b01);
      wait_quiet(60, "sw_complete");
      chk("sw_pwr_kept", pwr_domain_on, 12'hFFF);

      // Simultaneous WDT + SW: WDT first, SW after one IDLE cycle.
      sb.push_back('{1'b0, 2'b10, 1'b0, 12'hFFF, 16});
      sb.push_back('{1'b0, 2'b01, 1'b0, 12'hFFF, 16});
      sw_rst_req  = 1'b1;
      wdt_timeout = 1'b1;
      @(posedge clk); #1;
      sw_rst_req = 1'b0;
      chk("sim_first_cause", rst_cause, 2'b10);
      wait_done(60, "sim_first_done");
      @(posedge clk); #1;
      chk("sim_gap_idle", busy, 0);
      @(posedge clk); #1;
      chk("sim_second_grst", global_reset, 0);
      chk("sim_second_cause", rst_cause, 2'b01);
      wait_done(60, "sim_second_done");
      wait_quiet(10, "sim_quiet");
      repeat (20) @(posedge clk); #1;
      chk("wdt_level_once", busy, 0);
      wdt_timeout = 1'b0;

      // Release timeout then retry.
      reset_status = 12'h001;
      sb.push_back('{1'b0, 2'b11, 1'b1, 12'hFFF, 16});
      pulse_sw();
      repeat (1039) @(posedge clk); #1;
      chk("to_before_err", err_timeout, 0);
      chk("to_release_high", global_reset, 1);
      @(posedge clk); #1;
      chk("to_err_set", err_timeout, 1);
      chk("to_cause_retry", rst_cause, 2'b11);
      chk("to_grst_low", global_reset, 0);
      reset_status = 12'h000;
      wait_quiet(60, "to_complete");
      chk("to_err_sticky", err_timeout, 1);

      // Two consecutive timeouts end in FAULT.
      init_done = 1'b0;
      sb.push_back('{1'b1, 2'b11, 1'b1, 12'hFFF, 0});
      pulse_sw();
      wait_fault(2200, "fault_reached");
      repeat (3) @(posedge clk); #1;
      pulse_sw();
      repeat (30) @(posedge clk); #1;
      chk("fault_held", fault, 1);
      chk("fault_hold_grst", global_reset, 0);
      chk("fault_ignores_sw", busy, 0);
      rst       = 1'b1;
      init_done = 1'b1;
      @(posedge clk); #1;
      chk_reset_vals("fault_exit");

      // Reset asserted mid-ASSERT aborts with no seq_done.
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      repeat (99) @(posedge clk); #1;
      chk("mid_in_assert_grst", global_reset, 0);
      chk("mid_in_assert_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_vals("mid_abort");
      repeat (20) @(posedge clk); #1;
      chk("mid_no_done", seq_done, 0);

      // Fresh boot after the abort.
      sb.push_back('{1'b0, 2'b00, 1'b0, 12'hFFF, 113});
      rst = 1'b0;
      @(posedge clk); #1;
      wait_quiet(200, "final_boot");
      repeat (3) @(posedge clk); #1;
      chk("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
